serial_adder_ctrl: RTL

Bit-serial adder controller that time-shares a single full-adder cell across all bits of a WIDTH-bit operand pair. It processes one bit per clock, LSB first, keeping the carry in a flip-flop between bits. It provides a start/busy/done handshake and holds a registered result. It sits beside the combinational ALU path as a low-area adder for the Hack datapath, and reuses the project's full-adder primitive as its only arithmetic element.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/fa_cell.sv | 21 ++
 rtl/serial_adder_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t                : FSM state encoding (IDLE / RUN / DONE)
//   - SERIAL_ADDER_WIDTH_DEF : default operand/result width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int SERIAL_ADDER_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// One-bit full adder; the only arithmetic element of the serial adder.
// Ports:
//   a, b  : input  operand bits
//   c     : input  carry-in
//   sum   : output a ^ b ^ c
//   carry : output majority(a, b, c)
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: one full-adder cell processes one bit per clock, LSB
// first, with the carry held in a flop between bits. Start/busy/done
// handshake; result, carry-out and signed overflow are registered and hold
// until the next completion or reset.
//
// Parameters:
//   WIDTH     : operand/result width (>= 2)
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   start     : request a new operation (sampled only in IDLE)
//   a, b      : operands, captured on an accepted start
//   cin       : carry-in, captured on an accepted start
//   sub       : subtract request (only honoured with SERIAL_ADDER_SUB_EN)
//   busy      : high while the FSM is in RUN
//   done      : one-cycle pulse when sum/cout/overflow are updated
//   sum       : registered result
//   cout      : registered final carry-out
//   overflow  : registered signed overflow (carry into MSB ^ carry out)
//
// Build option:
//   SERIAL_ADDER_SUB_EN : when defined, sub=1 captures ~b with carry-in 1,
//                         giving a - b. When undefined, sub is ignored.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef SERIAL_ADDER_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic             r_c_msb;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_done;

  logic             w_sub_eff;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_last_bit;

  // Subtraction is a + ~b + 1; with the feature compiled out SUB_EN is a
  // constant 0 and this collapses to plain capture of b and cin.
  assign w_sub_eff  = SUB_EN & sub;
  assign w_b_load   = w_sub_eff ? ~b : b;
  assign w_c_load   = w_sub_eff ? 1'b1 : cin;
  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

  fa_cell u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .c     (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last_bit) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res_sh   <= '0;
      r_carry    <= 1'b0;
      r_c_msb    <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= {w_fa_sum, r_res_sh[WIDTH-1:1]};
          r_carry  <= w_fa_carry;
          // The carry entering the MSB is needed later for signed overflow;
          // the counter stops at its terminal value rather than wrapping.
          if (w_last_bit) r_c_msb <= r_carry;
          else            r_cnt   <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_sum      <= r_res_sh;
          r_cout     <= r_carry;
          r_overflow <= r_c_msb ^ r_carry;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule : serial_adder_ctrl
